// File: rtl/axis_conj_frame_sched.sv
// axis_conj_frame_sched: per-frame channel/conjugate/mute scheduler; define CONJ_SCHED_FRAME_CNT_EN for frame_cnt/mute_cnt
module axis_conj_frame_sched #(
   parameter int FRAME_LEN = 4096,
   parameter int NUM_CH    = 4,
   parameter int CH_W      = 2
)(
   input  logic            s00_axis_aclk,
   input  logic            s00_axis_areset,
   input  logic            mon_tvalid,
   input  logic            mon_tready,
   input  logic            mon_tlast,
   input  logic            start,
   input  logic            stop,
   input  logic [CH_W-1:0] ref_ch,
   input  logic            mute_req,
   input  logic            err_clr,
   output logic            conj_enable,
   output logic            all_close,
   output logic [CH_W-1:0] cur_ch,
   output logic            busy,
   output logic            frame_err
`ifdef CONJ_SCHED_FRAME_CNT_EN
   ,output logic [31:0]    frame_cnt,
   output logic [15:0]     mute_cnt
`endif
);
   localparam int CW = $clog2(FRAME_LEN);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t          r_state;
   logic [CW-1:0]   r_beat_cnt;
   logic            r_mute_pend;
   logic            w_beat, w_last, w_bnd, w_err, w_fire, w_start;
   logic [CH_W-1:0] w_next_ch;
   assign w_beat    = (r_state != IDLE) & mon_tvalid & mon_tready;
   assign w_last    = r_beat_cnt == CW'(FRAME_LEN - 1);
   // a stray tlast resyncs the frame, so it is a boundary just like a full count
   assign w_bnd     = w_beat & (w_last | mon_tlast);
   assign w_err     = w_beat & (w_last ^ mon_tlast);
   assign w_fire    = w_beat & (r_beat_cnt == '0) & r_mute_pend;
   assign w_start   = (r_state == IDLE) & start & ~stop;
   assign w_next_ch = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset)
      if (s00_axis_areset) begin
         r_state     <= IDLE;
         r_beat_cnt  <= '0;
         r_mute_pend <= 1'b0;
         cur_ch      <= '0;
         conj_enable <= 1'b0;
         all_close   <= 1'b0;
         busy        <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         all_close <= w_fire;
         frame_err <= w_err | (frame_err & ~err_clr);
         if (w_beat) r_beat_cnt <= w_bnd ? '0 : r_beat_cnt + 1'b1;
         if (w_bnd) begin
            cur_ch      <= w_next_ch;
            conj_enable <= w_next_ch == ref_ch;
         end
         if (w_fire) r_mute_pend <= 1'b0;
         else if (mute_req && r_state == RUN) r_mute_pend <= 1'b1;
         case (r_state)
            IDLE: if (w_start) begin
               r_state     <= RUN;
               busy        <= 1'b1;
               cur_ch      <= '0;
               r_beat_cnt  <= '0;
               conj_enable <= ref_ch == '0;
            end
            RUN: if (stop) begin
               if (w_bnd || (r_beat_cnt == '0 && !w_beat)) begin
                  r_state     <= IDLE;
                  busy        <= 1'b0;
                  cur_ch      <= '0;
                  conj_enable <= 1'b0;
                  r_beat_cnt  <= '0;
                  r_mute_pend <= 1'b0;
               end else r_state <= DRAIN;
            end
            DRAIN: if (w_bnd) begin
               r_state     <= IDLE;
               busy        <= 1'b0;
               cur_ch      <= '0;
               conj_enable <= 1'b0;
               r_beat_cnt  <= '0;
               r_mute_pend <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
`ifdef CONJ_SCHED_FRAME_CNT_EN
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset)
      if (s00_axis_areset) begin
         frame_cnt <= '0;
         mute_cnt  <= '0;
      end else begin
         if (w_start) frame_cnt <= '0;
         else if (w_bnd) frame_cnt <= frame_cnt + 1'b1;
         if (w_fire && mute_cnt != '1) mute_cnt <= mute_cnt + 1'b1;
      end
`endif
endmodule

// File: tb/tb_axis_conj_frame_sched.sv
// tb_axis_conj_frame_sched: directed checks of frame scheduling, mute, stop/drain, framing errors and async reset
module tb_axis_conj_frame_sched;
   logic       clk = 1'b0, rst = 1'b1;
   logic       mon_tvalid = 1'b0, mon_tready = 1'b0, mon_tlast = 1'b0;
   logic       start = 1'b0, stop = 1'b0, mute_req = 1'b0, err_clr = 1'b0;
   logic [1:0] ref_ch = 2'd0;
   logic       conj_enable, all_close, busy, frame_err;
   logic [1:0] cur_ch;
`ifdef CONJ_SCHED_FRAME_CNT_EN
   logic [31:0] frame_cnt;
   logic [15:0] mute_cnt;
`endif
   int n_chk = 0, n_fail = 0, hs;
   axis_conj_frame_sched #(.FRAME_LEN(8), .NUM_CH(4), .CH_W(2)) dut (
      .s00_axis_aclk(clk), .s00_axis_areset(rst),
      .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
      .start(start), .stop(stop), .ref_ch(ref_ch), .mute_req(mute_req), .err_clr(err_clr),
      .conj_enable(conj_enable), .all_close(all_close), .cur_ch(cur_ch),
      .busy(busy), .frame_err(frame_err)
`ifdef CONJ_SCHED_FRAME_CNT_EN
      , .frame_cnt(frame_cnt), .mute_cnt(mute_cnt)
`endif
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input logic v, input logic r, input logic l);
      mon_tvalid = v; mon_tready = r; mon_tlast = l;
      @(posedge clk); #1;
   endtask
   initial begin
      repeat (2) step(0, 0, 0);
      chk("rst_busy", busy, 0); chk("rst_conj", conj_enable, 0); chk("rst_ch", cur_ch, 0);
      chk("rst_ac", all_close, 0); chk("rst_err", frame_err, 0);
      rst = 1'b0; step(0, 0, 0);
      start = 1; stop = 1; step(0, 0, 0); start = 0; stop = 0;
      chk("startstop_idle", busy, 0);
      ref_ch = 2'd2; start = 1; step(0, 0, 0); start = 0;
      chk("start_busy", busy, 1); chk("start_conj", conj_enable, 0); chk("start_ch", cur_ch, 0);
      for (int i = 0; i < 40; i++) begin
         step(1, 1, (i % 8) == 7);
         chk("t1_ch", cur_ch, ((i + 1) / 8) % 4);
         chk("t1_conj", conj_enable, (((i + 1) / 8) % 4) == 2);
      end
      chk("t1_err", frame_err, 0);
      stop = 1; step(0, 0, 0); stop = 0;
      chk("stop0_busy", busy, 0); chk("stop0_ch", cur_ch, 0); chk("stop0_conj", conj_enable, 0);
      start = 1; step(0, 0, 0); start = 0; hs = 0;
      for (int c = 0; c < 80; c++) begin
         step(1, c % 2 == 1, (hs % 8) == 7);
         if (c % 2 == 1) hs++;
         chk("t2_ch", cur_ch, (hs / 8) % 4);
         chk("t2_conj", conj_enable, ((hs / 8) % 4) == 2);
      end
      stop = 1; step(0, 0, 0); stop = 0;
      chk("t2_idle", busy, 0);
      start = 1; step(0, 0, 0); start = 0;
      for (int i = 0; i < 16; i++) begin
         mute_req = (i == 3 || i == 5); stop = (i == 11);
         step(1, 1, (i % 8) == 7);
         mute_req = 0; stop = 0;
         chk("t3_all_close", all_close, i == 8);
         if (i >= 11 && i < 15) chk("t3_drain_busy", busy, 1);
         if (i == 12) begin
            start = 1; step(0, 0, 0); start = 0;
            chk("t3_drain_start", busy, 1); chk("t3_drain_ch", cur_ch, 1);
         end
      end
      chk("t3_end_busy", busy, 0); chk("t3_end_ch", cur_ch, 0); chk("t3_end_conj", conj_enable, 0);
      start = 1; step(0, 0, 0); start = 0;
      for (int i = 0; i < 6; i++) begin
         step(1, 1, i == 5);
         chk("t4_early_err", frame_err, i == 5);
      end
      chk("t4_early_ch", cur_ch, 1);
      for (int i = 0; i < 8; i++) step(1, 1, i == 7);
      chk("t4_resync_ch", cur_ch, 2); chk("t4_resync_conj", conj_enable, 1); chk("t4_sticky", frame_err, 1);
      err_clr = 1; step(0, 0, 0); err_clr = 0;
      chk("t4_clr", frame_err, 0);
      for (int i = 0; i < 8; i++) step(1, 1, 0);
      chk("t4_nolast_err", frame_err, 1); chk("t4_nolast_ch", cur_ch, 3);
      err_clr = 1; step(0, 0, 0); err_clr = 0;
      chk("t4_clr2", frame_err, 0);
      for (int i = 0; i < 8; i++) begin
         err_clr = (i == 7); step(1, 1, 0); err_clr = 0;
      end
      chk("t4_set_wins", frame_err, 1); chk("t4_wrap_ch", cur_ch, 0); chk("t4_wrap_conj", conj_enable, 0);
      for (int i = 0; i < 20; i++) step(1, 1, (i % 8) == 7);
      mute_req = 1; step(0, 0, 0); mute_req = 0;
      chk("t5_pre_busy", busy, 1); chk("t5_pre_ch", cur_ch, 2); chk("t5_pre_conj", conj_enable, 1);
      #2 rst = 1'b1; #1;
      chk("t5_async_busy", busy, 0); chk("t5_async_ch", cur_ch, 0);
      chk("t5_async_conj", conj_enable, 0); chk("t5_async_err", frame_err, 0);
`ifdef CONJ_SCHED_FRAME_CNT_EN
      chk("t5_async_fcnt", frame_cnt, 0);
`endif
      @(posedge clk); #1 rst = 1'b0; step(0, 0, 0);
      ref_ch = 2'd0; start = 1; step(0, 0, 0); start = 0;
      chk("t5_ref0_conj", conj_enable, 1); chk("t5_ref0_ch", cur_ch, 0);
      for (int i = 0; i < 9; i++) step(1, 1, i == 7);
      chk("t5_pend_lost", all_close, 0); chk("t5_ch", cur_ch, 1); chk("t5_conj", conj_enable, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/axis_conj_frame_sched.md
Name: axis_conj_frame_sched

Overview:
- Frame-level scheduler for the conjugate (inverse-number) stage of the DOA spectrum pipeline.
- Snoops the AXIS handshake feeding that stage and counts FRAME_LEN-beat frames.
- Round-robins a channel index per frame and drives the stage's `enable` (conjugate the reference channel only) and `all_close` (mute) controls, changing them only on frame boundaries.
- Sits between the PS control registers and the conjugate stage.

Parameters:
- FRAME_LEN, 4096, beats per frame (FFT length); power of two, at least 4.
- NUM_CH, 4, number of interleaved channel frames per round.
- CH_W, 2, width of the channel index; must satisfy 2^CH_W >= NUM_CH.

Ports:
- s00_axis_aclk  in  1  sole clock.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- mon_tvalid  in  1  tvalid of the stream into the conjugate stage.
- mon_tready  in  1  tready of the same stream.
- mon_tlast  in  1  tlast of the same stream.
- start  in  1  single-cycle pulse; begin scheduling.
- stop  in  1  single-cycle pulse; stop after the current frame.
- ref_ch  in  CH_W  index of the channel whose spectrum is conjugated.
- mute_req  in  1  single-cycle pulse; request muting of the next frame.
- err_clr  in  1  clears frame_err.
- conj_enable  out  1  drives the conjugate stage's `enable`.
- all_close  out  1  drives the conjugate stage's `all_close` (one-cycle pulse).
- cur_ch  out  CH_W  channel index of the frame currently in flight.
- busy  out  1  high in RUN and DRAIN.
- frame_err  out  1  sticky framing error.

Behaviour:
- Interface: one clock, s00_axis_aclk. s00_axis_areset is asynchronous and active-high.
- Reset values:
  - state = IDLE, beat_cnt = 0, cur_ch = 0.
  - conj_enable = 0, all_close = 0, busy = 0, frame_err = 0, mute_pend = 0.
- Beat definition: beat = mon_tvalid & mon_tready. Beats are ignored in IDLE.
- State machine:
  - IDLE:
    - On start (with stop low) → RUN next cycle.
    - On entry to RUN: cur_ch = 0, beat_cnt = 0, conj_enable = (ref_ch == 0), sampled on the start cycle.
  - RUN:
    - Each beat increments beat_cnt.
    - On a beat with beat_cnt == FRAME_LEN-1 (frame boundary):
      - beat_cnt → 0.
      - cur_ch → cur_ch+1, wrapping NUM_CH-1 → 0.
      - conj_enable → (next cur_ch == ref_ch), using ref_ch sampled on that cycle.
    - stop → DRAIN.
    - If beat_cnt == 0 and there is no beat in the stop cycle → IDLE directly.
  - DRAIN:
    - Counts beats as in RUN.
    - On the frame-boundary beat → IDLE: conj_enable = 0, cur_ch = 0.
    - start is ignored.
- Mute:
  - mute_req in RUN sets mute_pend.
  - On the first beat of the next frame (beat with beat_cnt == 0), all_close pulses high for exactly 1 cycle (registered, 1-cycle latency) and mute_pend clears.
  - The conjugate stage then zeroes the following frame.
  - mute_req while mute_pend is already set is absorbed.
  - mute_req in IDLE or DRAIN is ignored.
- Framing check, on every beat in RUN or DRAIN:
  - tlast with beat_cnt != FRAME_LEN-1: set frame_err; resync beat_cnt → 0 and treat the beat as a frame boundary (cur_ch advances).
  - beat_cnt == FRAME_LEN-1 without tlast: set frame_err; boundary still taken.
- frame_err: set wins over err_clr in the same cycle; err_clr alone clears it next cycle.
- Simultaneous events:
  - start and stop in the same cycle in IDLE: stay IDLE.
  - stop in the same cycle as a frame-boundary beat in RUN: boundary applied, then → IDLE.
  - start in RUN: ignored.
- Reset mid-frame: all state returns to reset values immediately. The pending mute is lost.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: CONJ_SCHED_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [31:0] counting completed frame boundaries in RUN and DRAIN.
  - Reset 0, wraps at 2^32-1 → 0, cleared on start from IDLE.
  - Adds output mute_cnt [15:0] counting all_close pulses, saturating at 16'hFFFF.
- Undefined: neither port nor its counters exists. All other behaviour is identical.

Test Plan:
- FRAME_LEN=8, NUM_CH=4, ref_ch=2, start, 40 continuous beats with tlast every 8th → cur_ch 0,1,2,3,0; conj_enable high only during beats 16–23; frame_err = 0.
- Same setup, mon_tready toggling 50% → same per-frame cur_ch/conj_enable sequence, boundaries only on handshaked beats.
- mute_req at beat 3 → single all_close pulse one cycle after beat 8; second mute_req at beat 5 → no extra pulse.
- stop at beat 11 → busy stays 1 until the beat-15 handshake, then IDLE with conj_enable=0 and cur_ch=0; stop at beat_cnt 0 with no beat → IDLE next cycle.
- tlast at beat 5 → frame_err=1, cur_ch advances, next frame counted from 0; err_clr → frame_err=0.
- Assert s00_axis_areset at beat 20 → all outputs at reset values asynchronously; with CONJ_SCHED_FRAME_CNT_EN defined, frame_cnt = 0.
